// File: rtl/led_blink_monitor_pkg.sv
// Shared types and defaults for the LED blink-pattern monitor.
// FSM encodings are fixed so lab tools can decode o_dbg_state directly.
package led_blink_monitor_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_EXP_LEN  = 10;
  localparam int DEF_TOL      = 0;
  localparam int DEF_LOCK_CNT = 4;
  localparam int SYNC_DEPTH   = 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/led_blink_monitor_bit_sync.sv
// Synchronous-reset flop chain used as a metastability synchronizer
// for asynchronous board inputs. DEPTH flops, all clearing to 0.
module led_blink_monitor_bit_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chain <= '0;
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[DEPTH-1];

endmodule

// File: rtl/led_blink_monitor.sv
// Blink-pattern receiver: measures high/low phase lengths, flags bad phases and timeouts,
// tracks lock. Define BLINK_MON_SYNC_EN to put a two-flop synchronizer ahead of the sampler.
module led_blink_monitor
  import led_blink_monitor_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int EXP_LEN  = DEF_EXP_LEN,
  parameter int TOL      = DEF_TOL,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  output logic [CNT_W-1:0] hi_len,
  output logic [CNT_W-1:0] lo_len,
  output logic             meas_valid,
  output logic             meas_hi,
  output logic             err,
  output logic [7:0]       err_cnt,
  output logic             locked,
  output logic [1:0]       o_dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam int               TMO_LEN = EXP_LEN + TOL + 1;
  localparam logic [CNT_W:0]   EXP_W   = (CNT_W+1)'(EXP_LEN);
  localparam logic [CNT_W:0]   TOL_W   = (CNT_W+1)'(TOL);
  localparam int               RUN_W   = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_CNT);

  logic w_in_q;

`ifdef BLINK_MON_SYNC_EN
  led_blink_monitor_bit_sync #(
    .DEPTH (SYNC_DEPTH)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (in),
    .o_q   (w_in_q)
  );
`else
  assign w_in_q = in;
`endif

  logic             r_s;
  logic             r_s_d;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hi_len;
  logic [CNT_W-1:0] r_lo_len;
  logic             r_meas_valid;
  logic             r_meas_hi;
  logic             r_err;
  logic [7:0]       r_err_cnt;
  logic             r_locked;
  logic [RUN_W-1:0] r_run;
  logic             r_tmo;

  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_tmo_hit;
  logic [CNT_W:0]   w_cnt_ext;
  logic [CNT_W:0]   w_diff;
  logic             w_good;
  logic [RUN_W-1:0] w_run_inc;

  assign w_rise    = r_s & ~r_s_d;
  assign w_fall    = ~r_s & r_s_d;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_tmo_hit = (32'(w_cnt_inc) == 32'(TMO_LEN));
  // Deviation is taken one bit wider than the counter so it never wraps.
  assign w_cnt_ext = {1'b0, r_cnt};
  assign w_diff    = (w_cnt_ext >= EXP_W) ? (w_cnt_ext - EXP_W) : (EXP_W - w_cnt_ext);
  assign w_good    = (w_diff <= TOL_W);
  assign w_run_inc = (r_run == RUN_MAX) ? r_run : r_run + 1'b1;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_hi_len_nxt;
  logic [CNT_W-1:0] w_lo_len_nxt;
  logic             w_meas;
  logic             w_meas_hi_nxt;
  logic             w_bad;
  logic [7:0]       w_err_cnt_nxt;
  logic             w_locked_nxt;
  logic [RUN_W-1:0] w_run_nxt;
  logic             w_tmo_nxt;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_len_nxt  = r_hi_len;
    w_lo_len_nxt  = r_lo_len;
    w_meas        = 1'b0;
    w_meas_hi_nxt = 1'b0;
    w_bad         = 1'b0;
    w_err_cnt_nxt = r_err_cnt;
    w_locked_nxt  = r_locked;
    w_run_nxt     = r_run;
    w_tmo_nxt     = r_tmo;

    case (r_state)
      ST_WAIT: begin
        if (w_rise) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = CNT_ONE;
          w_tmo_nxt   = 1'b0;
        end else if (w_fall) begin
          w_state_nxt = ST_LOW;
          w_cnt_nxt   = CNT_ONE;
          w_tmo_nxt   = 1'b0;
        end
      end
      ST_HIGH: begin
        if (w_fall) begin
          w_hi_len_nxt  = r_cnt;
          w_meas        = 1'b1;
          w_meas_hi_nxt = 1'b1;
          w_state_nxt   = ST_LOW;
          w_cnt_nxt     = CNT_ONE;
          w_tmo_nxt     = 1'b0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_tmo_hit && !r_tmo) begin
            w_bad     = 1'b1;
            w_tmo_nxt = 1'b1;
          end
        end
      end
      ST_LOW: begin
        if (w_rise) begin
          w_lo_len_nxt  = r_cnt;
          w_meas        = 1'b1;
          w_meas_hi_nxt = 1'b0;
          w_state_nxt   = ST_HIGH;
          w_cnt_nxt     = CNT_ONE;
          w_tmo_nxt     = 1'b0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_tmo_hit && !r_tmo) begin
            w_bad     = 1'b1;
            w_tmo_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_WAIT;
      end
    endcase

    // A phase that already timed out has been charged once; its closing edge only reports length.
    if (w_meas && !r_tmo) begin
      if (w_good) begin
        w_run_nxt = w_run_inc;
        if (w_run_inc == RUN_MAX) begin
          w_locked_nxt = 1'b1;
        end
      end else begin
        w_bad = 1'b1;
      end
    end

    if (w_bad) begin
      w_err_cnt_nxt = sat_inc8(r_err_cnt);
      w_locked_nxt  = 1'b0;
      w_run_nxt     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s          <= 1'b0;
      r_s_d        <= 1'b0;
      r_state      <= ST_WAIT;
      r_cnt        <= '0;
      r_hi_len     <= '0;
      r_lo_len     <= '0;
      r_meas_valid <= 1'b0;
      r_meas_hi    <= 1'b0;
      r_err        <= 1'b0;
      r_err_cnt    <= '0;
      r_locked     <= 1'b0;
      r_run        <= '0;
      r_tmo        <= 1'b0;
    end else begin
      r_s          <= w_in_q;
      r_s_d        <= r_s;
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hi_len     <= w_hi_len_nxt;
      r_lo_len     <= w_lo_len_nxt;
      r_meas_valid <= w_meas;
      r_meas_hi    <= w_meas_hi_nxt;
      r_err        <= w_bad;
      r_err_cnt    <= w_err_cnt_nxt;
      r_locked     <= w_locked_nxt;
      r_run        <= w_run_nxt;
      r_tmo        <= w_tmo_nxt;
    end
  end

  // meas_valid is a one-cycle strobe with no ready: consumers capture hi_len/lo_len on it.
  assign hi_len      = r_hi_len;
  assign lo_len      = r_lo_len;
  assign meas_valid  = r_meas_valid;
  assign meas_hi     = r_meas_hi;
  assign err         = r_err;
  assign err_cnt     = r_err_cnt;
  assign locked      = r_locked;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_led_blink_monitor.sv
// Bench for led_blink_monitor: two instances (nominal and narrow/tolerant) driven by phase tables
// plus hand sequences for latency, timeout timing and mid-phase reset. Honours BLINK_MON_SYNC_EN.
module tb_led_blink_monitor;

`ifdef BLINK_MON_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  logic in_a;
  logic in_b;

  logic [15:0] a_hi, a_lo;
  logic        a_mv, a_mh, a_err, a_lock;
  logic [7:0]  a_ec;
  logic [1:0]  a_st;
  logic [3:0]  b_hi, b_lo;
  logic        b_mv, b_mh, b_err, b_lock;
  logic [7:0]  b_ec;
  logic [1:0]  b_st;

  led_blink_monitor #(.CNT_W(16), .EXP_LEN(4), .TOL(0), .LOCK_CNT(4)) dut_a (
    .clk(clk), .reset(reset), .in(in_a), .hi_len(a_hi), .lo_len(a_lo),
    .meas_valid(a_mv), .meas_hi(a_mh), .err(a_err), .err_cnt(a_ec),
    .locked(a_lock), .o_dbg_state(a_st)
  );

  led_blink_monitor #(.CNT_W(4), .EXP_LEN(4), .TOL(1), .LOCK_CNT(4)) dut_b (
    .clk(clk), .reset(reset), .in(in_b), .hi_len(b_hi), .lo_len(b_lo),
    .meas_valid(b_mv), .meas_hi(b_mh), .err(b_err), .err_cnt(b_ec),
    .locked(b_lock), .o_dbg_state(b_st)
  );

  // phase record: level, length, then the measurement this phase must produce
  typedef struct {
    logic       lvl;
    int         len;
    logic       has;
    int         m_len;
    logic       m_err;
    logic [7:0] m_ec;
    logic       m_lock;
    logic [1:0] m_tmo;
  } vec_t;

  vec_t tab_a[15];
  vec_t tab_b[10];

  // scoreboard: {meas_hi, len, err, err_cnt, locked, timeout pulses in phase}
  logic [28:0] exp_a_q[$];
  logic [28:0] exp_b_q[$];
  logic [1:0]  tmo_a, tmo_b;
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [28:0] mk(input logic hi, input logic [15:0] len, input logic e,
                                     input logic [7:0] ec, input logic lk, input logic [1:0] tmo);
    return {hi, len, e, ec, lk, tmo};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic mon();
    logic [28:0] got;
    logic [28:0] e;
    if (a_mv) begin
      got = mk(a_mh, a_mh ? a_hi : a_lo, a_err, a_ec, a_lock, tmo_a);
      if (exp_a_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL meas_a: got unexpected measurement %h, expected none", got);
      end else begin
        e = exp_a_q.pop_front();
        check("meas_a", 64'(got), 64'(e));
      end
      tmo_a = 2'd0;
    end else if (a_err && tmo_a != 2'd3) begin
      tmo_a = tmo_a + 2'd1;
    end
    if (b_mv) begin
      got = mk(b_mh, 16'(b_mh ? b_hi : b_lo), b_err, b_ec, b_lock, tmo_b);
      if (exp_b_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL meas_b: got unexpected measurement %h, expected none", got);
      end else begin
        e = exp_b_q.pop_front();
        check("meas_b", 64'(got), 64'(e));
      end
      tmo_b = 2'd0;
    end else if (b_err && tmo_b != 2'd3) begin
      tmo_b = tmo_b + 2'd1;
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    mon();
  endtask

  task automatic rst_seq();
    check("q_empty_a", 64'(exp_a_q.size()), 64'd0);
    check("q_empty_b", 64'(exp_b_q.size()), 64'd0);
    reset = 1'b1;
    in_a  = 1'b0;
    in_b  = 1'b0;
    tick();
    check("rst_a", 64'({a_hi, a_lo, a_mv, a_mh, a_err, a_ec, a_lock, a_st}), 64'd0);
    check("rst_b", 64'({b_hi, b_lo, b_mv, b_mh, b_err, b_ec, b_lock, b_st}), 64'd0);
    tick();
    reset = 1'b0;
    exp_a_q.delete();
    exp_b_q.delete();
    tmo_a = 2'd0;
    tmo_b = 2'd0;
  endtask

  task automatic apply(input bit use_b, input vec_t v);
    logic [28:0] e;
    if (v.has) begin
      e = mk(v.lvl, 16'(v.m_len), v.m_err, v.m_ec, v.m_lock, v.m_tmo);
      if (use_b) exp_b_q.push_back(e);
      else       exp_a_q.push_back(e);
    end
    if (use_b) in_b = v.lvl;
    else       in_a = v.lvl;
    repeat (v.len) tick();
  endtask

  initial begin
    //            lvl  len has mlen err  ec    lock tmo
    tab_a[0]  = '{1'b1, 4, 1'b1, 4, 1'b0, 8'd0, 1'b0, 2'd0};
    tab_a[1]  = '{1'b0, 4, 1'b1, 4, 1'b0, 8'd0, 1'b0, 2'd0};
    tab_a[2]  = '{1'b1, 4, 1'b1, 4, 1'b0, 8'd0, 1'b0, 2'd0};
    tab_a[3]  = '{1'b0, 4, 1'b1, 4, 1'b0, 8'd0, 1'b1, 2'd0};
    tab_a[4]  = '{1'b1, 6, 1'b1, 6, 1'b0, 8'd1, 1'b0, 2'd1};
    tab_a[5]  = '{1'b0, 4, 1'b1, 4, 1'b0, 8'd1, 1'b0, 2'd0};
    tab_a[6]  = '{1'b1, 4, 1'b1, 4, 1'b0, 8'd1, 1'b0, 2'd0};
    tab_a[7]  = '{1'b0, 4, 1'b1, 4, 1'b0, 8'd1, 1'b0, 2'd0};
    tab_a[8]  = '{1'b1, 4, 1'b1, 4, 1'b0, 8'd1, 1'b1, 2'd0};
    tab_a[9]  = '{1'b0, 2, 1'b1, 2, 1'b1, 8'd2, 1'b0, 2'd0};
    tab_a[10] = '{1'b1, 1, 1'b1, 1, 1'b1, 8'd3, 1'b0, 2'd0};
    tab_a[11] = '{1'b0, 4, 1'b1, 4, 1'b0, 8'd3, 1'b0, 2'd0};
    tab_a[12] = '{1'b1, 5, 1'b1, 5, 1'b0, 8'd4, 1'b0, 2'd1};
    tab_a[13] = '{1'b0, 3, 1'b1, 3, 1'b1, 8'd5, 1'b0, 2'd0};
    tab_a[14] = '{1'b1, 4, 1'b0, 0, 1'b0, 8'd0, 1'b0, 2'd0};

    tab_b[0]  = '{1'b1, 3,  1'b1, 3,  1'b0, 8'd0, 1'b0, 2'd0};
    tab_b[1]  = '{1'b0, 5,  1'b1, 5,  1'b0, 8'd0, 1'b0, 2'd0};
    tab_b[2]  = '{1'b1, 4,  1'b1, 4,  1'b0, 8'd0, 1'b0, 2'd0};
    tab_b[3]  = '{1'b0, 2,  1'b1, 2,  1'b1, 8'd1, 1'b0, 2'd0};
    tab_b[4]  = '{1'b1, 3,  1'b1, 3,  1'b0, 8'd1, 1'b0, 2'd0};
    tab_b[5]  = '{1'b0, 5,  1'b1, 5,  1'b0, 8'd1, 1'b0, 2'd0};
    tab_b[6]  = '{1'b1, 4,  1'b1, 4,  1'b0, 8'd1, 1'b0, 2'd0};
    tab_b[7]  = '{1'b0, 4,  1'b1, 4,  1'b0, 8'd1, 1'b1, 2'd0};
    tab_b[8]  = '{1'b1, 20, 1'b1, 15, 1'b0, 8'd2, 1'b0, 2'd1};
    tab_b[9]  = '{1'b0, 4,  1'b0, 0,  1'b0, 8'd0, 1'b0, 2'd0};

    reset = 1'b1;
    in_a  = 1'b0;
    in_b  = 1'b0;
    tmo_a = 2'd0;
    tmo_b = 2'd0;
    rst_seq();

    // nominal blinker, lock, stretched phase, short and minimum phases
    for (int i = 0; i < 15; i++) apply(1'b0, tab_a[i]);
    repeat (LAT + 2) tick();
    rst_seq();

    // latency of a single falling edge to meas_valid
    in_a = 1'b1;
    repeat (4) tick();
    check("state_high", 64'(a_st), 64'(S_HIGH));
    exp_a_q.push_back(mk(1'b1, 16'd4, 1'b0, 8'd0, 1'b0, 2'd0));
    in_a = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      tick();
      check("lat_meas_valid", 64'(a_mv), 64'(i == LAT - 1));
    end
    check("state_low", 64'(a_st), 64'(S_LOW));
    rst_seq();

    // reset in the middle of a low phase two cycles in, then first edge after reset
    in_a = 1'b1;
    repeat (4) tick();
    exp_a_q.push_back(mk(1'b1, 16'd4, 1'b0, 8'd0, 1'b0, 2'd0));
    in_a = 1'b0;
    repeat (LAT + 1) tick();
    rst_seq();
    check("post_rst_wait", 64'(a_st), 64'(S_WAIT));
    repeat (3) tick();
    in_a = 1'b1;
    repeat (4) tick();
    exp_a_q.push_back(mk(1'b1, 16'd4, 1'b0, 8'd0, 1'b0, 2'd0));
    in_a = 1'b0;
    repeat (LAT + 1) tick();
    rst_seq();

    // tolerance window and counter saturation on the narrow instance
    for (int i = 0; i < 10; i++) apply(1'b1, tab_b[i]);
    repeat (LAT + 2) tick();
    rst_seq();

    // exact timeout cycle: single err pulse when the count reaches EXP_LEN+TOL+1
    in_b = 1'b1;
    for (int i = 0; i < LAT + 9; i++) begin
      tick();
      check("tmo_cycle", 64'(b_err), 64'(i == LAT + 4));
    end
    check("tmo_errcnt_lock", 64'({b_ec, b_lock}), 64'({8'd1, 1'b0}));
    exp_b_q.push_back(mk(1'b1, 16'd15, 1'b0, 8'd1, 1'b0, 2'd1));
    repeat (20 - (LAT + 9)) tick();
    in_b = 1'b0;
    repeat (LAT + 1) tick();
    rst_seq();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
